rr_mux: RTL and testbench

Registered, parameterised N-channel, W-bit multiplexer with a valid/ready handshake on every input and on the output. It succeeds the single-bit combinational 2:1 mux: it widens the data path, adds any number of channels, and adds a fixed-select mode and a fair round-robin mode. It sits between several producer blocks and one consumer, with one output register stage.

---
 rtl/rr_mux_if.sv | 30 +++
 rtl/rr_mux.sv | 93 +++++++++
 tb/tb_rr_mux.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/rr_mux_if.sv
// Handshake bundle for rr_mux: per-channel valid/ready inputs, one valid/ready
// output, plus the mode/select controls that steer the grant.
interface rr_mux_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int SELW = $clog2(CHANNELS);

    logic                      mode;
    logic [SELW-1:0]           sel;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SELW-1:0]           out_chan;
    logic                      out_valid;
    logic                      out_ready;

    // Producer/consumer side (drives channel inputs and accepts the output)
    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    // Mux side
    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/rr_mux.sv
// N-channel registered mux with fixed-select and round-robin grant modes.
// One output register stage; grant is combinational from inputs and ptr.
module rr_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int SELW    = $clog2(CHANNELS)
) (
    input logic    clk,
    input logic    rst_n,
    rr_mux_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t          state, state_nxt;
    logic [SELW-1:0] ptr, ptr_nxt;
    logic [SELW-1:0] chan_q, chan_nxt;
    logic [WIDTH-1:0] data_q, data_nxt;
    logic [SELW-1:0] gnt_idx;
    logic            gnt_vld;
    logic            load;
    logic            xfer;
    int              rr_idx;

    // Grant selection: fixed channel, or first valid channel at/after ptr
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        rr_idx  = 0;
        if (!bus.mode) begin
            // sel may exceed the channel count when CHANNELS is not a power of two
            if (int'(bus.sel) < CHANNELS && bus.in_valid[bus.sel]) begin
                gnt_vld = 1'b1;
                gnt_idx = bus.sel;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                // ptr is always < CHANNELS, so one conditional subtract wraps it
                rr_idx = int'(ptr) + k;
                if (rr_idx >= CHANNELS) rr_idx = rr_idx - CHANNELS;
                if (!gnt_vld && bus.in_valid[rr_idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SELW'(rr_idx);
                end
            end
        end
    end

    // Register can accept when empty or being drained; nothing accepted in reset
    assign load = rst_n && (state == EMPTY || bus.out_ready);
    assign xfer = gnt_vld && load;

    // Only the granted channel sees ready
    always_comb begin
        bus.in_ready = '0;
        if (xfer) bus.in_ready[gnt_idx] = 1'b1;
    end

    // Next-state: capture on transfer, empty on drain without refill
    always_comb begin
        state_nxt = state;
        data_nxt  = data_q;
        chan_nxt  = chan_q;
        ptr_nxt   = ptr;
        if (xfer) begin
            state_nxt = FULL;
            data_nxt  = bus.in_data[int'(gnt_idx)*WIDTH +: WIDTH];
            chan_nxt  = gnt_idx;
            if (bus.mode)
                ptr_nxt = (int'(gnt_idx) == CHANNELS-1) ? '0 : gnt_idx + 1'b1;
        end else if (state == FULL && bus.out_ready) begin
            state_nxt = EMPTY;
        end
    end

    // State, output word and round-robin pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            data_q <= '0;
            chan_q <= '0;
            ptr    <= '0;
        end else begin
            state  <= state_nxt;
            data_q <= data_nxt;
            chan_q <= chan_nxt;
            ptr    <= ptr_nxt;
        end
    end

    assign bus.out_valid = (state == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;
endmodule

// File: tb/tb_rr_mux.sv
// Self-checking bench for rr_mux: a 4-channel and a 3-channel instance run
// side by side against a transaction-level reference model.
module tb_rr_mux;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    rr_mux_if #(.WIDTH(8), .CHANNELS(4)) i4 ();
    rr_mux_if #(.WIDTH(8), .CHANNELS(3)) i3 ();

    rr_mux #(.WIDTH(8), .CHANNELS(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4.slave));
    rr_mux #(.WIDTH(8), .CHANNELS(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(i3.slave));

    // Reference model state, index 0 = 4-channel, 1 = 3-channel
    bit       m_valid [2];
    bit [7:0] m_data  [2];
    int       m_chan  [2];
    int       m_ptr   [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 0; m_data[d] = 0; m_chan[d] = 0; m_ptr[d] = 0;
        end
    endtask

    // Grant rule: fixed channel if in range and valid; else first valid from ptr
    function automatic int exp_grant(int c, bit mode, int sel, logic [3:0] valid, int ptr);
        if (!mode) return (sel < c && valid[sel]) ? sel : -1;
        for (int k = 0; k < c; k++)
            if (valid[(ptr + k) % c]) return (ptr + k) % c;
        return -1;
    endfunction

    // Check in_ready before the edge; returns the transferring channel or -1
    task automatic pre_check(input string tag, input int d, input int c, input bit mode,
                             input int sel, input logic [3:0] valid, input logic ordy,
                             input logic [3:0] rdy_obs, output int g);
        bit load;
        logic [3:0] exp;
        g    = exp_grant(c, mode, sel, valid, m_ptr[d]);
        load = !m_valid[d] || ordy;
        exp  = (g >= 0 && load) ? (4'b0001 << g) : 4'b0000;
        chk({tag, "_in_ready"}, 32'(rdy_obs), 32'(exp));
        if (!load) g = -1;
    endtask

    task automatic post(input int d, input int c, input bit mode, input logic ordy,
                        input logic [31:0] data, input int g);
        if (g >= 0) begin
            m_valid[d] = 1;
            m_data[d]  = data[g*8 +: 8];
            m_chan[d]  = g;
            if (mode) m_ptr[d] = (g + 1) % c;
        end else if (m_valid[d] && ordy) begin
            m_valid[d] = 0;
        end
    endtask

    // One clock cycle: entered and left at a negedge
    task automatic cyc();
        int g4, g3;
        #1;
        pre_check("c4", 0, 4, i4.mode, int'(i4.sel), i4.in_valid, i4.out_ready, i4.in_ready, g4);
        pre_check("c3", 1, 3, i3.mode, int'(i3.sel), {1'b0, i3.in_valid}, i3.out_ready,
                  {1'b0, i3.in_ready}, g3);
        @(posedge clk);
        post(0, 4, i4.mode, i4.out_ready, i4.in_data, g4);
        post(1, 3, i3.mode, i3.out_ready, {8'h00, i3.in_data}, g3);
        #1;
        chk("c4_out_valid", 32'(i4.out_valid), 32'(m_valid[0]));
        chk("c4_out_data",  32'(i4.out_data),  32'(m_data[0]));
        chk("c4_out_chan",  32'(i4.out_chan),  32'(m_chan[0]));
        chk("c3_out_valid", 32'(i3.out_valid), 32'(m_valid[1]));
        chk("c3_out_data",  32'(i3.out_data),  32'(m_data[1]));
        chk("c3_out_chan",  32'(i3.out_chan),  32'(m_chan[1]));
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_c4_out_valid"}, 32'(i4.out_valid), 0);
        chk({tag, "_c4_out_data"},  32'(i4.out_data),  0);
        chk({tag, "_c4_out_chan"},  32'(i4.out_chan),  0);
        chk({tag, "_c4_in_ready"},  32'(i4.in_ready),  0);
        chk({tag, "_c3_out_valid"}, 32'(i3.out_valid), 0);
        chk({tag, "_c3_in_ready"},  32'(i3.in_ready),  0);
    endtask

    initial begin
        i4.mode = 1'b1; i4.sel = '0; i4.in_data = 32'h44332211; i4.in_valid = 4'hF; i4.out_ready = 1'b1;
        i3.mode = 1'b1; i3.sel = '0; i3.in_data = 24'hC3B2A1;   i3.in_valid = 3'h7; i3.out_ready = 1'b1;
        model_reset();

        // Reset held with all inputs valid: outputs zero, no ready
        repeat (2) @(negedge clk);
        #1 chk_reset("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin fairness, all valid: 0,1,2,3,... and 0,1,2,0,1
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("rr4_seq_chan", 32'(i4.out_chan), 32'(k % 4));
            chk("rr4_seq_valid", 32'(i4.out_valid), 1);
            if (k < 5) chk("rr3_seq_chan", 32'(i3.out_chan), 32'(k % 3));
        end

        // Sparse valid 1010 -> 1,3,1,3
        i4.in_valid = 4'b1010;
        i3.in_valid = 3'b101;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("rr4_sparse_chan", 32'(i4.out_chan), (k % 2 == 0) ? 1 : 3);
        end

        // Fixed mode sel=2; 3-channel instance gets out-of-range sel=3
        i4.mode = 1'b0; i4.sel = 2'd2; i4.in_data = 32'h44332211; i4.in_valid = 4'hF;
        i3.mode = 1'b0; i3.sel = 2'd3; i3.in_valid = 3'h7;
        #1 chk("fix_in_ready", 32'(i4.in_ready), 32'b0100);
        chk("fix3_in_ready", 32'(i3.in_ready), 0);
        cyc();
        chk("fix_out_data", 32'(i4.out_data), 32'h33);
        chk("fix_out_chan", 32'(i4.out_chan), 2);
        i4.in_valid = 4'b1011;
        #1 chk("fix_novalid_in_ready", 32'(i4.in_ready), 0);
        cyc();
        chk("fix_novalid_out_valid", 32'(i4.out_valid), 0);
        chk("fix3_sel3_out_valid", 32'(i3.out_valid), 0);

        // Backpressure: hold 8'h22, then release with same-cycle reload
        i4.sel = 2'd1; i4.in_valid = 4'hF;
        cyc();
        chk("bp_load_data", 32'(i4.out_data), 32'h22);
        i4.sel = 2'd3; i4.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_in_ready", 32'(i4.in_ready), 0);
            cyc();
            chk("bp_hold_data", 32'(i4.out_data), 32'h22);
            chk("bp_hold_valid", 32'(i4.out_valid), 1);
        end
        i4.out_ready = 1'b1;
        #1 chk("bp_release_in_ready", 32'(i4.in_ready), 32'b1000);
        cyc();
        chk("bp_release_valid", 32'(i4.out_valid), 1);
        chk("bp_release_data", 32'(i4.out_data), 32'h44);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            i4.mode = 1'($urandom); i4.sel = 2'($urandom); i4.in_data = $urandom;
            i4.in_valid = 4'($urandom); i4.out_ready = ($urandom_range(0, 3) != 0);
            i3.mode = 1'($urandom); i3.sel = 2'($urandom); i3.in_data = 24'($urandom);
            i3.in_valid = 3'($urandom); i3.out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end

        // Asynchronous reset mid-stream while FULL
        i4.mode = 1'b1; i4.in_valid = 4'hF; i4.out_ready = 1'b0;
        i3.mode = 1'b1; i3.in_valid = 3'h7; i3.out_ready = 1'b0;
        cyc();
        chk("pre_rst_valid", 32'(i4.out_valid), 1);
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_async");
        model_reset();
        @(negedge clk);
        i4.out_ready = 1'b1; i3.out_ready = 1'b1;
        #1 chk("rst_low_in_ready", 32'(i4.in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_first_chan4", 32'(i4.out_chan), 0);
        chk("post_rst_first_chan3", 32'(i3.out_chan), 0);
        cyc();
        chk("post_rst_second_chan4", 32'(i4.out_chan), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
